// File: rtl/tweet_pkg.sv
// tweet_pkg
// Shared constants and types for the tweet message RAM scheduler.
//   ADDR_W     : RAM address width (depth = 2**ADDR_W)
//   DATA_W     : RAM word width
//   CHAR_LIMIT : first address at which store writes are refused
//   VALID_BIT  : bit of a RAM word that flags a valid entry
//   sched_state_e : scheduler state encoding (IDLE arbitration / CLEAR sweep)
package tweet_pkg;

  localparam int ADDR_W     = 8;
  localparam int DATA_W     = 16;
  localparam int CHAR_LIMIT = 160;
  localparam int VALID_BIT  = 15;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } sched_state_e;

endpackage

// File: rtl/tweet_ram_clr.sv
// tweet_ram_clr
// Clear sweep engine: walks the sweep address from 0 to 2**ADDR_W-1, one
// address per cycle, and flags the end of the sweep.
// Ports:
//   clk, rst    : clock, asynchronous active-high reset
//   start       : begin a sweep (ignored while busy)
//   busy        : high for exactly 2**ADDR_W cycles after start
//   done        : one-cycle pulse in the cycle after busy falls
//   sweep_addr  : address the scheduler should clear next
//   sweep_end   : counter MSB; every address has been issued
module tweet_ram_clr #(
  parameter int ADDR_W = tweet_pkg::ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] sweep_addr,
  output logic              sweep_end
);
  import tweet_pkg::*;

  localparam logic [ADDR_W:0] CNT_ONE = {{ADDR_W{1'b0}}, 1'b1};

  // One bit wider than the address so the MSB marks completion and the
  // counter never wraps back into the address range.
  logic [ADDR_W:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt  <= '0;
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      done <= 1'b0;
      if (busy) begin
        if (cnt[ADDR_W]) begin
          busy <= 1'b0;
          done <= 1'b1;
        end else begin
          cnt <= cnt + CNT_ONE;
        end
      end else if (start) begin
        // Address 0 is issued by the scheduler on the start edge itself,
        // so the counter resumes at 1.
        busy <= 1'b1;
        cnt  <= CNT_ONE;
      end
    end
  end

  assign sweep_addr = cnt[ADDR_W-1:0];
  assign sweep_end  = cnt[ADDR_W];

endmodule

// File: rtl/tweet_ram_sched.sv
// tweet_ram_sched
// Shares the single port of the tweet message RAM between the clear sweep,
// the serial-store writer and the playback reader. One access is granted per
// cycle by fixed priority (clear, write, read). Store writes at or above
// CHAR_LIMIT are acknowledged but not performed. Read data returns two cycles
// after the read grant, registered from ram_dout.
//
// Build option: define TWEET_RAM_CLR_EN to compile in the clear engine.
// Without it clr_req is ignored and clr_busy/clr_done stay 0.
//
// Ports:
//   sysclk, reset        : clock, asynchronous active-high reset
//   clr_req              : pulse, start a full-RAM clear
//   clr_busy, clr_done   : sweep running / one-cycle completion pulse
//   wr_req/addr/data     : store write request (held until wr_gnt)
//   wr_gnt, wr_drop      : write acknowledge / write refused (over limit)
//   rd_req/addr          : playback read request (held until rd_gnt)
//   rd_gnt               : read acknowledge
//   rd_valid, rd_data    : read data strobe and held read data
//   ram_write/addr/din   : registered RAM controls
//   ram_dout             : RAM read data, valid one cycle after ram_addr
module tweet_ram_sched #(
  parameter int ADDR_W     = tweet_pkg::ADDR_W,
  parameter int DATA_W     = tweet_pkg::DATA_W,
  parameter int CHAR_LIMIT = tweet_pkg::CHAR_LIMIT
) (
  input  logic              sysclk,
  input  logic              reset,
  input  logic              clr_req,
  output logic              clr_busy,
  output logic              clr_done,
  input  logic              wr_req,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_gnt,
  output logic              wr_drop,
  input  logic              rd_req,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic              rd_gnt,
  output logic              rd_valid,
  output logic [DATA_W-1:0] rd_data,
  output logic              ram_write,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_din,
  input  logic [DATA_W-1:0] ram_dout
);
  import tweet_pkg::*;

  function automatic logic below_limit(input logic [ADDR_W-1:0] addr);
    return (int'(addr) < CHAR_LIMIT);
  endfunction

  sched_state_e      state_q, state_d;
  logic              clr_go, clr_start;
  logic [ADDR_W-1:0] sweep_addr;
  logic              sweep_end;
  logic              wr_live, rd_live;
  logic              wr_win, rd_win, wr_ok;
  logic              ram_write_d;
  logic [ADDR_W-1:0] ram_addr_d;
  logic [DATA_W-1:0] ram_din_d;
  logic              vld_p1;

`ifdef TWEET_RAM_CLR_EN
  tweet_ram_clr #(
    .ADDR_W(ADDR_W)
  ) u_clr (
    .clk       (sysclk),
    .rst       (reset),
    .start     (clr_start),
    .busy      (clr_busy),
    .done      (clr_done),
    .sweep_addr(sweep_addr),
    .sweep_end (sweep_end)
  );
  assign clr_go = clr_req;
`else
  assign clr_busy   = 1'b0;
  assign clr_done   = 1'b0;
  assign sweep_addr = '0;
  assign sweep_end  = 1'b0;
  assign clr_go     = 1'b0;
  logic unused_clr;
  assign unused_clr = clr_req ^ clr_start;
`endif

  // A requester may still show req in the cycle it sees its grant; masking
  // it here prevents a second grant for the same request.
  assign wr_live = wr_req & ~wr_gnt;
  assign rd_live = rd_req & ~rd_gnt;
  assign wr_ok   = below_limit(wr_addr);

  always_comb begin
    state_d     = state_q;
    clr_start   = 1'b0;
    wr_win      = 1'b0;
    rd_win      = 1'b0;
    ram_write_d = 1'b0;
    ram_addr_d  = ram_addr;
    ram_din_d   = ram_din;
    case (state_q)
      ST_IDLE: begin
        if (clr_go) begin
          // The start edge already issues the write to address 0.
          state_d     = ST_CLEAR;
          clr_start   = 1'b1;
          ram_write_d = 1'b1;
          ram_addr_d  = '0;
          ram_din_d   = '0;
        end else if (wr_live) begin
          wr_win      = 1'b1;
          ram_write_d = wr_ok;
          ram_addr_d  = wr_addr;
          ram_din_d   = wr_data;
        end else if (rd_live) begin
          rd_win      = 1'b1;
          ram_addr_d  = rd_addr;
        end
      end
      ST_CLEAR: begin
        if (sweep_end) begin
          state_d = ST_IDLE;
        end else begin
          ram_write_d = 1'b1;
          ram_addr_d  = sweep_addr;
          ram_din_d   = '0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Stage p0: grant, RAM command registers; rd_gnt is the read tag.
  always_ff @(posedge sysclk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      ram_write <= 1'b0;
      ram_addr  <= '0;
      ram_din   <= '0;
      wr_gnt    <= 1'b0;
      wr_drop   <= 1'b0;
      rd_gnt    <= 1'b0;
    end else begin
      state_q   <= state_d;
      ram_write <= ram_write_d;
      ram_addr  <= ram_addr_d;
      ram_din   <= ram_din_d;
      wr_gnt    <= wr_win;
      wr_drop   <= wr_win & ~wr_ok;
      rd_gnt    <= rd_win;
    end
  end

  // Stage p1: RAM is reading; stage p2: capture ram_dout.
  always_ff @(posedge sysclk or posedge reset) begin
    if (reset) begin
      vld_p1   <= 1'b0;
      rd_valid <= 1'b0;
      rd_data  <= '0;
    end else begin
      vld_p1   <= rd_gnt;
      rd_valid <= vld_p1;
      if (vld_p1) begin
        rd_data <= ram_dout;
      end
    end
  end

endmodule

// File: tb/tb_tweet_ram_sched.sv
module tb_tweet_ram_sched;

  localparam int AW  = 8;
  localparam int DW  = 16;
  localparam int LIM = 160;

  logic          sysclk = 1'b0;
  logic          reset, clr_req, wr_req, rd_req;
  logic [AW-1:0] wr_addr, rd_addr, ram_addr;
  logic [DW-1:0] wr_data, rd_data, ram_din, ram_dout;
  logic          clr_busy, clr_done, wr_gnt, wr_drop, rd_gnt, rd_valid, ram_write;

  always #5 sysclk = ~sysclk;

  tweet_ram_sched dut (
    .sysclk   (sysclk),
    .reset    (reset),
    .clr_req  (clr_req),
    .clr_busy (clr_busy),
    .clr_done (clr_done),
    .wr_req   (wr_req),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .wr_gnt   (wr_gnt),
    .wr_drop  (wr_drop),
    .rd_req   (rd_req),
    .rd_addr  (rd_addr),
    .rd_gnt   (rd_gnt),
    .rd_valid (rd_valid),
    .rd_data  (rd_data),
    .ram_write(ram_write),
    .ram_addr (ram_addr),
    .ram_din  (ram_din),
    .ram_dout (ram_dout)
  );

  // Physical single-port RAM: synchronous read, one cycle latency.
  logic [DW-1:0] mem [256];
  initial begin
    ram_dout <= '0;
    for (int i = 0; i < 256; i++) mem[i] <= {8'h5A, 8'(i)};
    forever begin
      @(posedge sysclk);
      if (ram_write) mem[ram_addr] <= ram_din;
      ram_dout <= mem[ram_addr];
    end
  end

  // Reference contents: what the RAM must hold according to the accepted writes.
  logic [DW-1:0] shadow [256];
  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    bit          wr;
    logic [7:0]  wa;
    logic [15:0] wd;
    bit          rd;
    logic [7:0]  ra;
    bit          exp_drop;
    logic [15:0] exp_rd;
  } vec_t;

  vec_t tbl [11];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_clr_busy"}, 32'(clr_busy), 0);
    chk({tag, "_clr_done"}, 32'(clr_done), 0);
    chk({tag, "_wr_gnt"},   32'(wr_gnt), 0);
    chk({tag, "_wr_drop"},  32'(wr_drop), 0);
    chk({tag, "_rd_gnt"},   32'(rd_gnt), 0);
    chk({tag, "_rd_valid"}, 32'(rd_valid), 0);
    chk({tag, "_ram_write"},32'(ram_write), 0);
    chk({tag, "_ram_addr"}, 32'(ram_addr), 0);
    chk({tag, "_ram_din"},  32'(ram_din), 0);
    chk({tag, "_rd_data"},  32'(rd_data), 0);
  endtask

  // Issue a write and/or read together and follow them for 8 cycles.
  // Rules: write granted one cycle after req; read granted after the write
  // (one cycle after req alone); data two cycles after the read grant.
  task automatic do_txn(input bit wr, input logic [7:0] wa, input logic [15:0] wd,
                        input bit rd, input logic [7:0] ra,
                        input bit exp_drop, input logic [15:0] exp_rd);
    int wg, rg, vc;
    wg = 0; rg = 0; vc = 0;
    if (wr && int'(wa) < LIM) shadow[wa] = wd;
    wr_req = wr; wr_addr = wa; wr_data = wd;
    rd_req = rd; rd_addr = ra;
    for (int c = 1; c <= 8; c++) begin
      @(negedge sysclk);
      if (wr_gnt) begin
        if (wg != 0 || !wr) chk("wr_extra_gnt", 1, 0);
        else begin
          wg = c;
          chk("wr_gnt_lat", c, 1);
          chk("wr_drop", 32'(wr_drop), 32'(exp_drop));
          chk("ram_write_on_wr", 32'(ram_write), 32'(!exp_drop));
          chk("ram_addr_wr", 32'(ram_addr), 32'(wa));
          chk("ram_din_wr", 32'(ram_din), 32'(wd));
          wr_req = 1'b0;
        end
      end else begin
        chk("ram_write_idle", 32'(ram_write), 0);
        chk("wr_drop_idle", 32'(wr_drop), 0);
      end
      if (rd_gnt) begin
        if (rg != 0 || !rd) chk("rd_extra_gnt", 1, 0);
        else begin
          rg = c;
          chk("rd_gnt_lat", c, wr ? 2 : 1);
          chk("ram_write_on_rd", 32'(ram_write), 0);
          chk("ram_addr_rd", 32'(ram_addr), 32'(ra));
          rd_req = 1'b0;
        end
      end
      if (rd_valid) begin
        if (vc != 0 || rg == 0) chk("rd_extra_valid", 1, 0);
        else begin
          vc = c;
          chk("rd_valid_lat", c, rg + 2);
          chk("rd_data", 32'(rd_data), 32'(exp_rd));
        end
      end else if (vc != 0) begin
        chk("rd_data_hold", 32'(rd_data), 32'(exp_rd));
      end
    end
    if (wr && wg == 0) chk("wr_gnt_timeout", 0, 1);
    if (rd && vc == 0) chk("rd_valid_timeout", 0, 1);
    wr_req = 1'b0;
    rd_req = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; clr_req = 1'b0; wr_req = 1'b0; rd_req = 1'b0;
    wr_addr = '0; wr_data = '0; rd_addr = '0;
    for (int i = 0; i < 256; i++) shadow[i] = {8'h5A, 8'(i)};

    tbl[0]  = '{1'b1, 8'd5,   16'h8041, 1'b0, 8'd0,   1'b0, 16'h0000};
    tbl[1]  = '{1'b0, 8'd0,   16'h0000, 1'b1, 8'd5,   1'b0, 16'h8041};
    tbl[2]  = '{1'b1, 8'd9,   16'h8123, 1'b1, 8'd9,   1'b0, 16'h8123};
    tbl[3]  = '{1'b1, 8'd160, 16'hABCD, 1'b0, 8'd0,   1'b1, 16'h0000};
    tbl[4]  = '{1'b0, 8'd0,   16'h0000, 1'b1, 8'd160, 1'b0, 16'h5AA0};
    tbl[5]  = '{1'b1, 8'd255, 16'hFFFF, 1'b1, 8'd159, 1'b1, 16'h5A9F};
    tbl[6]  = '{1'b1, 8'd159, 16'h7777, 1'b0, 8'd0,   1'b0, 16'h0000};
    tbl[7]  = '{1'b0, 8'd0,   16'h0000, 1'b1, 8'd159, 1'b0, 16'h7777};
    tbl[8]  = '{1'b1, 8'd0,   16'h1234, 1'b1, 8'd5,   1'b0, 16'h8041};
    tbl[9]  = '{1'b0, 8'd0,   16'h0000, 1'b1, 8'd0,   1'b0, 16'h1234};
    tbl[10] = '{1'b1, 8'd161, 16'h0BAD, 1'b1, 8'd161, 1'b1, 16'h5AA1};

    repeat (2) @(negedge sysclk);
    chk_zero("reset");
    reset = 1'b0;
    @(negedge sysclk);

    for (int v = 0; v < 11; v++)
      do_txn(tbl[v].wr, tbl[v].wa, tbl[v].wd, tbl[v].rd, tbl[v].ra,
             tbl[v].exp_drop, tbl[v].exp_rd);

    // Requester that drops its request one cycle late gets a single grant.
    wr_req = 1'b1; wr_addr = 8'd20; wr_data = 16'h2222;
    @(negedge sysclk); chk("late_wr_gnt", 32'(wr_gnt), 1);
    @(negedge sysclk); chk("late_no_regrant", 32'(wr_gnt), 0); wr_req = 1'b0;
    @(negedge sysclk); chk("late_no_regrant2", 32'(wr_gnt), 0);
    shadow[20] = 16'h2222;
    do_txn(1'b0, 8'd0, 16'h0, 1'b1, 8'd20, 1'b0, 16'h2222);

    // Reset right after a read grant flushes the read pipeline.
    rd_req = 1'b1; rd_addr = 8'd5;
    @(negedge sysclk); chk("flush_rd_gnt", 32'(rd_gnt), 1); rd_req = 1'b0;
    reset = 1'b1; #1;
    chk_zero("rd_abort");
    @(negedge sysclk); reset = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge sysclk);
      chk("flush_no_valid", 32'(rd_valid), 0);
    end

`ifdef TWEET_RAM_CLR_EN
    // Clear and write requested together: 256 sweep writes, done, then write.
    clr_req = 1'b1; wr_req = 1'b1; wr_addr = 8'd33; wr_data = 16'h8033;
    @(negedge sysclk);
    clr_req = 1'b0;
    for (int k = 0; k < 256; k++) begin
      chk("clr_busy", 32'(clr_busy), 1);
      chk("clr_ram_write", 32'(ram_write), 1);
      chk("clr_ram_addr", 32'(ram_addr), k);
      chk("clr_ram_din", 32'(ram_din), 0);
      chk("clr_no_early_done", 32'(clr_done), 0);
      chk("clr_wr_held", 32'(wr_gnt), 0);
      clr_req = (k == 10);
      @(negedge sysclk);
    end
    chk("clr_busy_end", 32'(clr_busy), 0);
    chk("clr_done", 32'(clr_done), 1);
    chk("clr_wr_still_held", 32'(wr_gnt), 0);
    chk("clr_end_no_write", 32'(ram_write), 0);
    @(negedge sysclk);
    chk("clr_wr_gnt", 32'(wr_gnt), 1);
    chk("clr_wr_addr", 32'(ram_addr), 33);
    chk("clr_wr_write", 32'(ram_write), 1);
    chk("clr_done_once", 32'(clr_done), 0);
    wr_req = 1'b0;
    @(negedge sysclk);
    chk("clr_no_restart", 32'(clr_busy), 0);
    for (int i = 0; i < 256; i++) shadow[i] = '0;
    shadow[33] = 16'h8033;
    do_txn(1'b0, 8'd0, 16'h0, 1'b1, 8'd0,   1'b0, 16'h0000);
    do_txn(1'b0, 8'd0, 16'h0, 1'b1, 8'd127, 1'b0, 16'h0000);
    do_txn(1'b0, 8'd0, 16'h0, 1'b1, 8'd255, 1'b0, 16'h0000);
    do_txn(1'b0, 8'd0, 16'h0, 1'b1, 8'd33,  1'b0, 16'h8033);

    // Reset while the sweep presents address 100.
    do_txn(1'b1, 8'd99,  16'h1199, 1'b0, 8'd0, 1'b0, 16'h0);
    do_txn(1'b1, 8'd100, 16'h1100, 1'b0, 8'd0, 1'b0, 16'h0);
    do_txn(1'b1, 8'd150, 16'h1150, 1'b0, 8'd0, 1'b0, 16'h0);
    clr_req = 1'b1;
    @(negedge sysclk);
    clr_req = 1'b0;
    repeat (100) @(negedge sysclk);
    chk("abort_at_100", 32'(ram_addr), 100);
    reset = 1'b1; #1;
    chk_zero("clr_abort");
    @(negedge sysclk); reset = 1'b0;
    for (int c = 0; c < 260; c++) begin
      @(negedge sysclk);
      if (clr_done || clr_busy || ram_write) chk("abort_quiet", 1, 0);
    end
    chk("abort_no_done", 32'(clr_done), 0);
    for (int i = 0; i < 100; i++) shadow[i] = '0;
    do_txn(1'b0, 8'd0, 16'h0, 1'b1, 8'd99,  1'b0, 16'h0000);
    do_txn(1'b0, 8'd0, 16'h0, 1'b1, 8'd100, 1'b0, 16'h1100);
    do_txn(1'b0, 8'd0, 16'h0, 1'b1, 8'd150, 1'b0, 16'h1150);
`else
    // Clear engine absent: clr_req has no effect and the write goes straight through.
    clr_req = 1'b1; wr_req = 1'b1; wr_addr = 8'd34; wr_data = 16'h8034;
    @(negedge sysclk);
    chk("noclr_wr_gnt", 32'(wr_gnt), 1);
    chk("noclr_ram_addr", 32'(ram_addr), 34);
    chk("noclr_busy", 32'(clr_busy), 0);
    wr_req = 1'b0; clr_req = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge sysclk);
      chk("noclr_busy_idle", 32'(clr_busy), 0);
      chk("noclr_done_idle", 32'(clr_done), 0);
      chk("noclr_write_idle", 32'(ram_write), 0);
    end
    shadow[34] = 16'h8034;
    do_txn(1'b0, 8'd0, 16'h0, 1'b1, 8'd34, 1'b0, 16'h8034);
`endif

    // Random traffic against the reference contents.
    for (int k = 0; k < 60; k++) begin
      bit          w, r;
      logic [7:0]  wa, ra;
      logic [15:0] wd, exp;
      w  = 1'($urandom_range(0, 1));
      r  = 1'($urandom_range(0, 1));
      if (!w && !r) r = 1'b1;
      wa = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(150, 170)) : 8'($urandom_range(0, 255));
      wd = 16'($urandom);
      ra = ($urandom_range(0, 1) == 0) ? wa : 8'($urandom_range(0, 255));
      exp = (w && int'(wa) < LIM && ra == wa) ? wd : shadow[ra];
      do_txn(w, wa, wd, r, ra, w && (int'(wa) >= LIM), exp);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/tweet_ram_sched.md
# tweet_ram_sched

Scheduler for the single-port 256x16 tweet message RAM. Shares the one RAM port between three users: the clear sweep engine, the serial-store writer and the playback reader. Grants one access per cycle by fixed priority, enforces the 160-character write limit, and returns read data with a fixed latency. Sits between the store/playback control logic and the `ram` instance in the tweetboard top level.

## Interface
- `ADDR_W`, 8, RAM address width; depth = 2^ADDR_W.
- `DATA_W`, 16, RAM word width; bit 15 is the "entry valid" flag.
- `CHAR_LIMIT`, 160, first address at which store writes are refused.
- `sysclk` in 1, system clock.
- `reset` in 1, asynchronous, active-high reset.
- `clr_req` in 1, one-cycle pulse that starts a full-RAM clear.
- `clr_busy` out 1, high while the clear sweep runs.
- `clr_done` out 1, one-cycle pulse after the last clear write.
- `wr_req` in 1, store write request; held until `wr_gnt`.
- `wr_addr` in ADDR_W, store write address.
- `wr_data` in DATA_W, store write data.
- `wr_gnt` out 1, one-cycle write acknowledge.
- `wr_drop` out 1, pulses together with `wr_gnt` when `wr_addr >= CHAR_LIMIT`; no RAM write occurs.
- `rd_req` in 1, playback read request; held until `rd_gnt`.
- `rd_addr` in ADDR_W, playback read address.
- `rd_gnt` out 1, one-cycle read acknowledge.
- `rd_valid` out 1, one-cycle strobe qualifying `rd_data`.
- `rd_data` out DATA_W, read data; holds its value between strobes.
- `ram_write` out 1, RAM write enable (registered).
- `ram_addr` out ADDR_W, RAM address (registered).
- `ram_din` out DATA_W, RAM write data (registered).
- `ram_dout` in DATA_W, RAM read data; valid one cycle after `ram_addr` is presented.

## Operation
- States: IDLE, CLEAR.
- **IDLE**
  - Each cycle, evaluate pending requests in priority order: `clr_req`, then `wr_req`, then `rd_req`.
  - `clr_req`: go to CLEAR with sweep address = 0.
  - Write winner: register `ram_addr=wr_addr`, `ram_din=wr_data`, and `ram_write=1` unless the address is at or above the limit. Pulse `wr_gnt` (and `wr_drop` if the write is refused).
  - Read winner: register `ram_addr=rd_addr` and `ram_write=0`. Pulse `rd_gnt`. Push a tag into the 2-deep read pipeline.
- **CLEAR**
  - Each cycle, drive `ram_write=1`, `ram_din=0`, `ram_addr`=sweep address, then increment the sweep address.
  - After address 2^ADDR_W−1, pulse `clr_done`, deassert `clr_busy` and return to IDLE.
  - Exactly 2^ADDR_W writes per clear.
- `wr_req`/`rd_req` arriving during CLEAR stay pending and are served after it, write first.
- `clr_req` during CLEAR is ignored.
- Requester drops `req` in the cycle it sees `gnt`. The scheduler ignores a port's `req` in the cycle directly after granting that port, so no double grant occurs.
- A write followed by a read of the same address returns the new data (ordering is by grant).
- `ram_write` is 0 whenever no write is granted.

## Timing
- Reset values:
  - `clr_busy`, `clr_done`, `wr_gnt`, `wr_drop`, `rd_gnt`, `rd_valid`, `ram_write` = 0.
  - `ram_addr`, `ram_din`, `rd_data` = 0.
  - State = IDLE; read pipeline empty.
- Grant latency: `req` high in cycle N → `gnt` and RAM signals asserted in cycle N+1.
- Read latency: `rd_gnt` in cycle M → `rd_valid`/`rd_data` in cycle M+2, with `rd_data` registered from `ram_dout`.
- Throughput: one access per cycle; back-to-back reads fully pipelined.
- Clear: `clr_req` in cycle N → `clr_busy` from N+1 to N+256; `clr_done` in N+257 (ADDR_W=8).
- Simultaneous `clr_req` and `wr_req`: clear wins; the write is granted in cycle N+258.
- Reset asserted mid-clear or mid-read aborts immediately: no `clr_done`, read pipeline flushed, no `rd_valid`.
- Sweep counter is ADDR_W+1 bits wide; its MSB marks the end of the sweep, and the counter does not wrap.

## Configuration
- `TWEET_RAM_CLR_EN`
  - Defined: the clear engine and CLEAR state are compiled in, as described above.
  - Undefined: `clr_req` is ignored, `clr_busy` and `clr_done` are tied 0, and only IDLE arbitration between write and read remains.

## Structure
- Package `tweet_pkg`: `ADDR_W`, `DATA_W`, `CHAR_LIMIT`, `VALID_BIT` = 15, and the scheduler state enum.
- One sub-module: `tweet_ram_clr` (sweep counter, `clr_busy`/`clr_done` generation), instantiated only under `TWEET_RAM_CLR_EN`.

## Test plan
- Write `wr_addr`=5, `wr_data`=16'h8041, then read address 5 → `wr_gnt` at +1, `rd_valid` at `rd_gnt`+2 with `rd_data`=16'h8041.
- `wr_req` and `rd_req` in the same cycle, both on address 9 → write granted first, read granted next cycle, returns the new data.
- Write to `wr_addr`=160 → `wr_gnt` and `wr_drop` pulse, `ram_write` stays 0; a read of 160 returns the old content.
- `clr_req` then reads of addresses 0, 127 and 255 → `clr_busy` for 256 cycles, `clr_done` one pulse, all reads return 0.
- `wr_req` raised during a clear → held off until after `clr_done`, then granted; data present on readback.
- Reset asserted at sweep address 100 → all outputs 0 next cycle, no `clr_done`; addresses ≥100 keep prior data.
